// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbitration logic.
//   arb_state_t : cache_arbiter FSM states
//   arb_side_t  : which requester (instruction or data cache) owns the port
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } arb_side_t;

endpackage

// File: rtl/arb_line_buffer.sv
// Cache-line holding register with load enable and asynchronous clear.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   load  : capture d on the rising edge
//   d     : incoming line
//   q     : held line
module arb_line_buffer #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter placing I-cache and D-cache line requests onto one
// physical-memory port, one transaction at a time.
//   clk, rst                      : clock, asynchronous active-low reset
//   icache_read/address           : instruction line read request
//   icache_rdata/resp             : returned line + one-cycle completion
//   dcache_read/write/address/wdata : data line read or writeback request
//   dcache_rdata/resp             : returned line + one-cycle completion
//   pmem_read/write/address/wdata : memory request, held until pmem_resp
//   pmem_rdata/resp               : memory completion
//   i_grant_count/d_grant_count   : completed transactions per side (wrapping)
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [31:0]           i_grant_count,
  output logic [31:0]           d_grant_count
);

  arb_state_t            state_q, state_d;
  arb_side_t             last_grant_q;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           i_cnt_q, d_cnt_q;
  logic [LINE_WIDTH-1:0] line_q;

  logic i_req, d_req, grant_i, grant_d, serving, capture;

  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  // On a tie the side that did not win last time goes first.
  assign grant_d = (state_q == IDLE) && d_req && (!i_req || last_grant_q == SIDE_I);
  assign grant_i = (state_q == IDLE) && i_req && !grant_d;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign capture = serving && pmem_resp;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = SERVE_D;
        else if (grant_i) state_d = SERVE_I;
      end
      SERVE_I: if (pmem_resp) state_d = DONE_I;
      SERVE_D: if (pmem_resp) state_d = DONE_D;
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= SIDE_I;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d || grant_i) begin
        last_grant_q <= grant_d ? SIDE_D : SIDE_I;
        op_write_q   <= grant_d & dcache_write;
        addr_q       <= grant_d ? dcache_address : icache_address;
      end
      if (capture && state_q == SERVE_I) i_cnt_q <= i_cnt_q + 32'd1;
      if (capture && state_q == SERVE_D) d_cnt_q <= d_cnt_q + 32'd1;
    end
  end

  // Writeback line is only meaningful for data-side grants.
  arb_line_buffer #(.WIDTH(LINE_WIDTH)) u_wdata_buf (
    .clk   (clk),
    .rst_n (rst),
    .load  (grant_d),
    .d     (dcache_wdata),
    .q     (pmem_wdata)
  );

  arb_line_buffer #(.WIDTH(LINE_WIDTH)) u_rdata_buf (
    .clk   (clk),
    .rst_n (rst),
    .load  (capture),
    .d     (pmem_rdata),
    .q     (line_q)
  );

  assign pmem_read     = serving && !op_write_q;
  assign pmem_write    = serving && op_write_q;
  assign pmem_address  = addr_q;
  assign icache_resp   = (state_q == DONE_I);
  assign dcache_resp   = (state_q == DONE_D);
  assign icache_rdata  = line_q;
  assign dcache_rdata  = line_q;
  assign i_grant_count = i_cnt_q;
  assign d_grant_count = d_cnt_q;

endmodule
